// File: rtl/imem_access_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters
// (CPU fetch and loader/debug) and the single-port memory macro.
interface imem_access_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  // Fetch port (read-only)
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic [DATA_W-1:0] fetch_rdata;
  logic              fetch_rvalid;

  // Loader / debug port (read/write)
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_boot_done;
  logic              ld_gnt;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_rvalid;

  // Memory macro side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Core run enable
  logic              cpu_run;

  // Arbiter view
  modport slave (
    input  fetch_req, fetch_addr,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_boot_done,
    input  mem_rdata,
    output fetch_gnt, fetch_rdata, fetch_rvalid,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output cpu_run
  );

  // Environment view (requesters + memory macro)
  modport master (
    output fetch_req, fetch_addr,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_boot_done,
    output mem_rdata,
    input  fetch_gnt, fetch_rdata, fetch_rvalid,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  cpu_run
  );

endinterface

// File: rtl/imem_access_arbiter.sv
// Arbiter sharing a single-port synchronous instruction memory between the
// CPU fetch port and the program loader. BOOT gives the loader exclusive
// access; RUN gives fetch priority with a bounded starvation count so the
// loader is guaranteed a slot.
module imem_access_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_access_arbiter_if.slave bus
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Who owns the read data returning from the macro next cycle
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LD    = 2'd2
  } owner_t;

  state_t           state_reg, state_next;
  owner_t           owner_reg, owner_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  logic              fetch_gnt;
  logic              ld_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // State, starvation counter and read-owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BOOT;
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Grant decision, boot exit and starvation bookkeeping
  always_comb begin
    state_next = state_reg;
    fetch_gnt  = 1'b0;
    ld_gnt     = 1'b0;

    case (state_reg)
      BOOT: begin
        // Loader owns the memory; fetch is locked out until the image is in.
        ld_gnt = bus.ld_req;
        if (bus.ld_boot_done) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.fetch_req && bus.ld_req) begin
          // Contention: fetch wins unless the loader has waited long enough.
          if (starve_cnt_reg == STARVE_LIMIT) begin
            ld_gnt = 1'b1;
          end else begin
            fetch_gnt = 1'b1;
          end
        end else begin
          fetch_gnt = bus.fetch_req;
          ld_gnt    = bus.ld_req;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase

    // Count fetch wins only while the loader is actually waiting.
    starve_cnt_next = starve_cnt_reg;
    if (ld_gnt || !bus.ld_req) begin
      starve_cnt_next = '0;
    end else if (fetch_gnt && starve_cnt_reg != STARVE_LIMIT) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    // Remember which requester gets next cycle's read data; writes return nothing.
    owner_next = OWN_NONE;
    if (fetch_gnt) begin
      owner_next = OWN_FETCH;
    end else if (ld_gnt && !bus.ld_we) begin
      owner_next = OWN_LD;
    end
  end

  // Address / write-data mux from the granted requester
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    if (fetch_gnt) begin
      addr_sel = bus.fetch_addr;
    end else if (ld_gnt) begin
      addr_sel  = bus.ld_addr;
      wdata_sel = bus.ld_wdata;
    end
  end

  assign bus.fetch_gnt    = fetch_gnt;
  assign bus.ld_gnt       = ld_gnt;

  assign bus.mem_en       = fetch_gnt | ld_gnt;
  assign bus.mem_we       = ld_gnt & bus.ld_we;
  assign bus.mem_addr     = addr_sel;
  assign bus.mem_wdata    = wdata_sel;

  // Read data is a straight passthrough; the owner register qualifies it.
  assign bus.fetch_rdata  = bus.mem_rdata;
  assign bus.ld_rdata     = bus.mem_rdata;
  assign bus.fetch_rvalid = (owner_reg == OWN_FETCH);
  assign bus.ld_rvalid    = (owner_reg == OWN_LD);

  assign bus.cpu_run      = (state_reg == RUN);

endmodule
